// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a single-port multi-cycle unified memory (optional round-robin: ARB_RR_EN)
module mem_port_arbiter #(
    parameter int WORD_LEN    = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [WORD_LEN-1:0] if_addr,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_ready,
    input  logic                mem_rd_en,
    input  logic                mem_wr_en,
    input  logic [WORD_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_wdata,
    output logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_ready,
    output logic                freeze,
    output logic                sram_en,
    output logic                sram_we,
    output logic [WORD_LEN-1:0] sram_addr,
    output logic [WORD_LEN-1:0] sram_wdata,
    input  logic [WORD_LEN-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Counter value of the final enabled cycle of an access.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_sram_en;
    logic                r_sram_we;
    logic [WORD_LEN-1:0] r_sram_addr;
    logic [WORD_LEN-1:0] r_sram_wdata;
    logic [WORD_LEN-1:0] r_if_rdata;
    logic [WORD_LEN-1:0] r_mem_rdata;
    logic                r_if_ready;
    logic                r_mem_ready;

    state_t              w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic                w_sram_en_nxt;
    logic                w_sram_we_nxt;
    logic [WORD_LEN-1:0] w_sram_addr_nxt;
    logic [WORD_LEN-1:0] w_sram_wdata_nxt;
    logic [WORD_LEN-1:0] w_if_rdata_nxt;
    logic [WORD_LEN-1:0] w_mem_rdata_nxt;
    logic                w_if_ready_nxt;
    logic                w_mem_ready_nxt;

    logic                w_data_req;
    logic                w_pick_data;

    assign w_data_req = mem_rd_en | mem_wr_en;

`ifdef ARB_RR_EN
    // 1 = last completed access was a data access, 0 = instruction fetch.
    logic r_last_grant;
    logic w_last_grant_nxt;

    // Data wins when alone, or when both pend and the fetch side was served last.
    assign w_pick_data = w_data_req & (~if_req | ~r_last_grant);
`else
    // Fixed priority: data always wins over instruction fetch.
    assign w_pick_data = w_data_req;
`endif

    // Stall the pipeline while any requester is waiting for its ready pulse.
    assign freeze = (if_req & ~r_if_ready) | (w_data_req & ~r_mem_ready);

    assign if_rdata   = r_if_rdata;
    assign if_ready   = r_if_ready;
    assign mem_rdata  = r_mem_rdata;
    assign mem_ready  = r_mem_ready;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

    // Next-state and next-register values; everything holds unless changed below.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sram_en_nxt    = r_sram_en;
        w_sram_we_nxt    = r_sram_we;
        w_sram_addr_nxt  = r_sram_addr;
        w_sram_wdata_nxt = r_sram_wdata;
        w_if_rdata_nxt   = r_if_rdata;
        w_mem_rdata_nxt  = r_mem_rdata;
        w_if_ready_nxt   = 1'b0;
        w_mem_ready_nxt  = 1'b0;
`ifdef ARB_RR_EN
        w_last_grant_nxt = r_last_grant;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pick_data) begin
                    w_state_nxt      = S_DATA;
                    w_cnt_nxt        = 4'd0;
                    w_sram_en_nxt    = 1'b1;
                    w_sram_we_nxt    = mem_wr_en;
                    w_sram_addr_nxt  = mem_addr;
                    w_sram_wdata_nxt = mem_wdata;
                end else if (if_req) begin
                    w_state_nxt      = S_INST;
                    w_cnt_nxt        = 4'd0;
                    w_sram_en_nxt    = 1'b1;
                    w_sram_we_nxt    = 1'b0;
                    w_sram_addr_nxt  = if_addr;
                end
            end
            S_DATA, S_INST: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt   = S_RESP;
                    w_cnt_nxt     = 4'd0;
                    w_sram_en_nxt = 1'b0;
                    w_sram_we_nxt = 1'b0;
                    if (r_state == S_INST) begin
                        w_if_rdata_nxt = sram_rdata;
                        w_if_ready_nxt = 1'b1;
                    end else begin
                        // A store leaves the load data register untouched.
                        if (!r_sram_we) begin
                            w_mem_rdata_nxt = sram_rdata;
                        end
                        w_mem_ready_nxt = 1'b1;
                    end
`ifdef ARB_RR_EN
                    w_last_grant_nxt = (r_state == S_DATA);
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_RESP: begin
                // Requesters still hold the finished request here, so it is ignored.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sram_en    <= w_sram_en_nxt;
            r_sram_we    <= w_sram_we_nxt;
            r_sram_addr  <= w_sram_addr_nxt;
            r_sram_wdata <= w_sram_wdata_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_mem_rdata  <= w_mem_rdata_nxt;
            r_if_ready   <= w_if_ready_nxt;
            r_mem_ready  <= w_mem_ready_nxt;
        end
    end

`ifdef ARB_RR_EN
    // Remember who was served last; reset favours the fetch side as last served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed, table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_rd_en = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] sram_rdata = '0;

    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
    logic        if_ready, mem_ready, freeze, sram_en, sram_we;

    logic [31:0] d1_if_rdata, d1_mem_rdata, d1_sram_addr, d1_sram_wdata;
    logic        d1_if_ready, d1_mem_ready, d1_freeze, d1_sram_en, d1_sram_we;
    logic [31:0] d15_if_rdata, d15_mem_rdata, d15_sram_addr, d15_sram_wdata;
    logic        d15_if_ready, d15_mem_ready, d15_freeze, d15_sram_en, d15_sram_we;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_LEN(32), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_port_arbiter #(.WORD_LEN(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_rdata(d1_if_rdata), .if_ready(d1_if_ready), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(d1_mem_rdata), .mem_ready(d1_mem_ready), .freeze(d1_freeze),
        .sram_en(d1_sram_en), .sram_we(d1_sram_we), .sram_addr(d1_sram_addr),
        .sram_wdata(d1_sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_port_arbiter #(.WORD_LEN(32), .MEM_LATENCY(15)) dut15 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .if_rdata(d15_if_rdata), .if_ready(d15_if_ready), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(d15_mem_rdata), .mem_ready(d15_mem_ready), .freeze(d15_freeze),
        .sram_en(d15_sram_en), .sram_we(d15_sram_we), .sram_addr(d15_sram_addr),
        .sram_wdata(d15_sram_wdata), .sram_rdata(sram_rdata)
    );

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        rd;
        logic        wr;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [31:0] sr;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ifr;
        logic        e_mr;
        logic [31:0] e_ird;
        logic [31:0] e_mrd;
        logic        e_frz;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory model for hand sequences: data depends on the address on the port.
    task automatic model_rdata();
        sram_rdata = sram_addr ^ K;
    endtask

    initial begin
        int t_mr, t_ir, exp_mr, exp_ir;
        int en1, en15, t1, t15;
        logic [31:0] aa [3];
        logic drop_m, drop_i;

        // ifr ifa rd wr ma wd sr | en we addr wd ifr mr ird mrd frz
        tbl[0]  = '{0, 0,     0, 0, 0,     0,     0,     0, 0, 0,     0,     0, 0, 0,     0,     0};
        tbl[1]  = '{1, 32'h10, 0, 0, 0,    0,     0,     0, 0, 0,     0,     0, 0, 0,     0,     1};
        tbl[2]  = '{1, 32'h10, 0, 0, 0,    0,     32'h8420000A, 1, 0, 32'h10, 0, 0, 0, 0,  0,     1};
        tbl[3]  = '{1, 32'h10, 0, 0, 0,    0,     32'h8420000A, 1, 0, 32'h10, 0, 0, 0, 0,  0,     1};
        tbl[4]  = '{1, 32'h10, 0, 0, 0,    0,     0,     0, 0, 0,     0,     1, 0, 32'h8420000A, 0, 0};
        tbl[5]  = '{0, 0,     0, 0, 0,     0,     0,     0, 0, 0,     0,     0, 0, 32'h8420000A, 0, 0};
        tbl[6]  = '{0, 0,     0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0,     0, 0, 32'h8420000A, 0, 1};
        tbl[7]  = '{0, 0,     0, 1, 32'h100, 32'hDEADBEEF, 32'h12345678, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h8420000A, 0, 1};
        tbl[8]  = '{0, 0,     0, 1, 32'h100, 32'hDEADBEEF, 32'h12345678, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h8420000A, 0, 1};
        tbl[9]  = '{0, 0,     0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0,     0, 1, 32'h8420000A, 0, 0};
        tbl[10] = '{0, 0,     0, 0, 0,     0,     0,     0, 0, 0,     0,     0, 0, 32'h8420000A, 0, 0};
        tbl[11] = '{0, 0,     1, 0, 32'h200, 0,   0,     0, 0, 0,     0,     0, 0, 32'h8420000A, 0, 1};
        tbl[12] = '{0, 0,     1, 0, 32'h200, 0,   32'hCAFEF00D, 1, 0, 32'h200, 0, 0, 0, 32'h8420000A, 0, 1};
        tbl[13] = '{0, 0,     1, 0, 32'h200, 0,   32'hCAFEF00D, 1, 0, 32'h200, 0, 0, 0, 32'h8420000A, 0, 1};
        tbl[14] = '{0, 0,     1, 0, 32'h200, 0,   0,     0, 0, 0,     0,     0, 1, 32'h8420000A, 32'hCAFEF00D, 0};
        tbl[15] = '{0, 0,     0, 0, 0,     0,     0,     0, 0, 0,     0,     0, 0, 32'h8420000A, 32'hCAFEF00D, 0};

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_sram_en", {31'd0, sram_en}, 32'd0);
        check("rst_sram_we", {31'd0, sram_we}, 32'd0);
        check("rst_sram_addr", sram_addr, 32'd0);
        check("rst_sram_wdata", sram_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_freeze", {31'd0, freeze}, 32'd0);

        // Fetch, store, load from the vector table
        for (int i = 0; i < 16; i++) begin
            cyc();
            if_req     = tbl[i].ifr;
            if_addr    = tbl[i].ifa;
            mem_rd_en  = tbl[i].rd;
            mem_wr_en  = tbl[i].wr;
            mem_addr   = tbl[i].ma;
            mem_wdata  = tbl[i].wd;
            sram_rdata = tbl[i].sr;
            @(negedge clk);
            check($sformatf("v%0d_sram_en", i), {31'd0, sram_en}, {31'd0, tbl[i].e_en});
            check($sformatf("v%0d_sram_we", i), {31'd0, sram_we}, {31'd0, tbl[i].e_we});
            check($sformatf("v%0d_if_ready", i), {31'd0, if_ready}, {31'd0, tbl[i].e_ifr});
            check($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, tbl[i].e_mr});
            check($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].e_ird);
            check($sformatf("v%0d_mem_rdata", i), mem_rdata, tbl[i].e_mrd);
            check($sformatf("v%0d_freeze", i), {31'd0, freeze}, {31'd0, tbl[i].e_frz});
            if (tbl[i].e_en) check($sformatf("v%0d_sram_addr", i), sram_addr, tbl[i].e_addr);
            if (tbl[i].e_we) check($sformatf("v%0d_sram_wdata", i), sram_wdata, tbl[i].e_wd);
        end

        // Conflict: fetch and load raised together
`ifdef ARB_RR_EN
        exp_ir = 3;
        exp_mr = 7;
`else
        exp_mr = 3;
        exp_ir = 7;
`endif
        t_mr = -1;
        t_ir = -1;
        drop_m = 1'b0;
        drop_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            model_rdata();
            if (k == 0) begin
                if_req    = 1'b1;
                if_addr   = 32'h40;
                mem_rd_en = 1'b1;
                mem_addr  = 32'h300;
            end
            if (drop_m) mem_rd_en = 1'b0;
            if (drop_i) if_req = 1'b0;
            @(negedge clk);
            if (mem_ready && t_mr < 0) begin t_mr = k; drop_m = 1'b1; end
            if (if_ready && t_ir < 0) begin t_ir = k; drop_i = 1'b1; end
        end
        check("conf_mem_ready_cycle", t_mr, exp_mr);
        check("conf_if_ready_cycle", t_ir, exp_ir);
        check("conf_mem_rdata", mem_rdata, 32'h300 ^ K);
        check("conf_if_rdata", if_rdata, 32'h40 ^ K);

        // Reset in the second enabled cycle of a store
        for (int k = 0; k < 10; k++) begin
            cyc();
            model_rdata();
            case (k)
                0: begin mem_wr_en = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h55AA; end
                2: rst = 1'b1;
                3: begin rst = 1'b0; mem_wr_en = 1'b0; end
                5: begin if_req = 1'b1; if_addr = 32'h44; end
                9: if_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (k == 2) check("rstmid_en_before", {31'd0, sram_en}, 32'd1);
            if (k == 3) begin
                check("rstmid_sram_en", {31'd0, sram_en}, 32'd0);
                check("rstmid_sram_we", {31'd0, sram_we}, 32'd0);
                check("rstmid_mem_ready", {31'd0, mem_ready}, 32'd0);
                check("rstmid_if_rdata", if_rdata, 32'd0);
                check("rstmid_mem_rdata", mem_rdata, 32'd0);
                check("rstmid_sram_addr", sram_addr, 32'd0);
                check("rstmid_sram_wdata", sram_wdata, 32'd0);
                check("rstmid_freeze", {31'd0, freeze}, 32'd0);
            end
            if (k == 4) check("rstmid_no_ready", {31'd0, mem_ready | sram_en}, 32'd0);
            if (k == 8) begin
                check("rstmid_fetch_ready", {31'd0, if_ready}, 32'd1);
                check("rstmid_fetch_rdata", if_rdata, 32'h44 ^ K);
            end
        end

        // Back-to-back loads with the address changing after each ready
        aa[0] = 32'h700;
        aa[1] = 32'h704;
        aa[2] = 32'h708;
        for (int k = 0; k < 12; k++) begin
            int ph;
            ph = k % 4;
            cyc();
            model_rdata();
            mem_rd_en = 1'b1;
            mem_addr  = aa[k / 4];
            @(negedge clk);
            check($sformatf("b2b%0d_sram_en", k), {31'd0, sram_en}, {31'd0, (ph == 1 || ph == 2)});
            check($sformatf("b2b%0d_mem_ready", k), {31'd0, mem_ready}, {31'd0, (ph == 3)});
            if (ph == 1 || ph == 2) check($sformatf("b2b%0d_sram_addr", k), sram_addr, aa[k / 4]);
            if (ph == 3) check($sformatf("b2b%0d_mem_rdata", k), mem_rdata, aa[k / 4] ^ K);
        end
        cyc();
        mem_rd_en = 1'b0;
        @(negedge clk);
        check("b2b_end_sram_en", {31'd0, sram_en}, 32'd0);

        // Latency extremes: MEM_LATENCY=1 and 15
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        en1 = 0;
        en15 = 0;
        t1 = -1;
        t15 = -1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            model_rdata();
            if (k == 0) begin mem_rd_en = 1'b1; mem_addr = 32'h600; end
            if (t15 >= 0) mem_rd_en = 1'b0;
            @(negedge clk);
            if (t1 < 0 && d1_sram_en) en1++;
            if (t15 < 0 && d15_sram_en) en15++;
            if (t1 < 0 && d1_mem_ready) t1 = k;
            if (t15 < 0 && d15_mem_ready) t15 = k;
        end
        check("lat1_en_cycles", en1, 1);
        check("lat1_ready_cycle", t1, 2);
        check("lat15_en_cycles", en15, 15);
        check("lat15_ready_cycle", t15, 16);
        check("lat15_mem_rdata", d15_mem_rdata, 32'h600 ^ K);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
